// File: rtl/regfile_dump_reader.sv
// Debug-side register file dump reader: walks all registers through a
// registered read port and streams them out over valid/ready.
module regfile_dump_reader #(
    parameter int NREGS = 16,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    input  logic          wr_snoop,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_idx,
    output logic          out_last
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_SEND,
        S_FIN
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx_nxt;
    logic [DW-1:0] r_fwd;
    logic          r_fwd_hit;
    logic [DW-1:0] r_out_data;
    logic [AW-1:0] r_out_idx;
    logic          r_out_last;
    logic          w_hit;
    logic          w_hs;
    logic [DW-1:0] w_value;

    assign w_hit = wr_snoop && (wr_addr == r_idx);
    assign w_hs  = (r_state == S_SEND) && out_ready;

    // The BRAM port returns pre-write data on a same-cycle write,
    // so writes seen in ISSUE or CAPTURE override the port output.
    assign w_value = w_hit     ? wr_data :
                     r_fwd_hit ? r_fwd   :
                                 rd_data;

    always_comb begin
        w_next    = r_state;
        w_idx_nxt = r_idx;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_idx_nxt = '0;
                    w_next    = S_ISSUE;
                end
            end
            S_ISSUE:   w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_SEND;
            S_SEND: begin
                if (w_hs) begin
                    if (r_out_last) begin
                        w_next = S_FIN;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                        w_next    = S_ISSUE;
                    end
                end
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (abort) begin
            w_next    = S_IDLE;
            w_idx_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_fwd      <= '0;
            r_fwd_hit  <= 1'b0;
            r_out_data <= '0;
            r_out_idx  <= '0;
            r_out_last <= 1'b0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_nxt;
            if (r_state == S_ISSUE) begin
                r_fwd_hit <= w_hit;
                if (w_hit) begin
                    r_fwd <= wr_data;
                end
            end
            if (r_state == S_CAPTURE && !abort) begin
                r_out_data <= w_value;
                r_out_idx  <= r_idx;
                r_out_last <= (r_idx == LAST_IDX);
            end
        end
    end

    assign rd_addr   = r_idx;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_FIN);
    assign out_valid = (r_state == S_SEND);
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;

endmodule
